// File: rtl/osc_pkg.sv
// Shared definitions for the emulated-time oscillator and its time-manager consumer.
package osc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } osc_state_t;

    // Fibonacci feedback taps 16,14,13,11 (bit positions 15,13,12,10).
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] SEED_DEFAULT = 16'hACE1;

    // All-ones value of a w-bit time quantity; reserved to mean "no constraint".
    function automatic logic [63:0] dt_max(input int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/osc_lfsr.sv
// 16-bit Fibonacci LFSR used as the jitter source; steps only when adv is high.
module osc_lfsr
    import osc_pkg::*;
#(
    parameter logic [15:0] SEED = SEED_DEFAULT
) (
    input  logic        emu_clk,
    input  logic        emu_rst_n,
    input  logic        adv,
    output logic [15:0] lfsr
);

    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            lfsr <= SEED;
        end else if (adv) begin
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/osc_model.sv
// Emulated-time clock source: publishes time to its next edge and toggles when the
// granted time reaches it. All outputs are registered so dt_req never depends on emu_dt.
module osc_model
    import osc_pkg::*;
#(
    parameter int          DT_WIDTH  = 27,
    parameter int          JIT_WIDTH = 8,
    parameter logic [15:0] SEED      = SEED_DEFAULT
) (
    input  logic                 emu_clk,
    input  logic                 emu_rst_n,
    input  logic [DT_WIDTH-1:0]  emu_dt,
    input  logic                 en,
    input  logic [DT_WIDTH-1:0]  t_hi,
    input  logic [DT_WIDTH-1:0]  t_lo,
    input  logic                 jit_en,
    input  logic [JIT_WIDTH-1:0] jit_amp,
    output logic [DT_WIDTH-1:0]  dt_req,
    output logic                 clk_val,
    output logic                 rise,
    output logic                 fall,
    output logic                 err_overshoot
);

    localparam logic [DT_WIDTH-1:0] DT_MAX = DT_WIDTH'(dt_max(DT_WIDTH));
    localparam logic [DT_WIDTH:0]   ONE    = (DT_WIDTH+1)'(1);
    localparam logic [DT_WIDTH:0]   HP_MAX = {1'b0, DT_MAX} - ONE;

    osc_state_t          state, state_nx;
    logic [DT_WIDTH-1:0] rem, rem_nx, dt_req_nx;
    logic [DT_WIDTH-1:0] hp_sel, hp;
    logic [DT_WIDTH:0]   hp_base, hp_m, hp_sum;
    logic                clk_nx, edge_hit, over, adv;
    logic [15:0]         lfsr;
    logic                unused_lfsr;

    assign unused_lfsr = ^lfsr[14:JIT_WIDTH];

    osc_lfsr #(.SEED(SEED)) u_lfsr (
        .emu_clk   (emu_clk),
        .emu_rst_n (emu_rst_n),
        .adv       (adv),
        .lfsr      (lfsr)
    );

    // Next half-period: t_hi follows a rise, t_lo follows a fall or a start from IDLE.
    always_comb begin
        hp_sel  = (state != IDLE && !clk_val) ? t_hi : t_lo;
        hp_base = (hp_sel == '0) ? ONE : {1'b0, hp_sel};
        hp_m    = jit_en ? (DT_WIDTH+1)'(lfsr[JIT_WIDTH-1:0] & jit_amp) : '0;
        if (lfsr[15]) begin
            hp_sum = (hp_m >= hp_base) ? ONE : hp_base - hp_m;
        end else begin
            hp_sum = hp_base + hp_m;
        end
        if (hp_sum > HP_MAX) begin
            hp_sum = HP_MAX;
        end
        hp = hp_sum[DT_WIDTH-1:0];
    end

    assign edge_hit = (state != IDLE) && (emu_dt >= rem);
    assign over     = (state != IDLE) && (emu_dt > rem);
    assign adv      = edge_hit && jit_en;

    always_comb begin
        state_nx = state;
        rem_nx   = rem;
        clk_nx   = clk_val;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nx = RUN;
                    rem_nx   = hp;
                end
            end
            RUN, DRAIN: begin
                if (edge_hit) begin
                    clk_nx = !clk_val;
                    rem_nx = hp;
                end else begin
                    rem_nx = rem - emu_dt;
                end
                // Stopping is only allowed once the level is low, so a high phase is never cut short.
                if (en) begin
                    state_nx = RUN;
                end else begin
                    state_nx = clk_nx ? DRAIN : IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        dt_req_nx = (state_nx == IDLE) ? DT_MAX : rem_nx;
    end

    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            state         <= IDLE;
            rem           <= '0;
            dt_req        <= DT_MAX;
            clk_val       <= 1'b0;
            rise          <= 1'b0;
            fall          <= 1'b0;
            err_overshoot <= 1'b0;
        end else begin
            state   <= state_nx;
            rem     <= rem_nx;
            dt_req  <= dt_req_nx;
            clk_val <= clk_nx;
            rise    <= edge_hit && !clk_val;
            fall    <= edge_hit && clk_val;
            if (over) begin
                err_overshoot <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_osc_model.sv
// Directed bench for osc_model: an abstract time/level model checked every cycle,
// plus hand-computed literal expectations for the key sequences.
module tb_osc_model;

    localparam int     DT_W   = 27;
    localparam int     JW     = 8;
    localparam longint DT_MAX = (longint'(1) << DT_W) - 1;

    logic            emu_clk = 1'b0;
    logic            emu_rst_n = 1'b1;
    logic [DT_W-1:0] emu_dt = '0;
    logic            en = 1'b0;
    logic [DT_W-1:0] t_hi = '0;
    logic [DT_W-1:0] t_lo = '0;
    logic            jit_en = 1'b0;
    logic [JW-1:0]   jit_amp = '0;
    logic [DT_W-1:0] dt_req;
    logic            clk_val, rise, fall, err_overshoot;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    osc_model #(.DT_WIDTH(DT_W), .JIT_WIDTH(JW), .SEED(16'hACE1)) dut (
        .emu_clk       (emu_clk),
        .emu_rst_n     (emu_rst_n),
        .emu_dt        (emu_dt),
        .en            (en),
        .t_hi          (t_hi),
        .t_lo          (t_lo),
        .jit_en        (jit_en),
        .jit_amp       (jit_amp),
        .dt_req        (dt_req),
        .clk_val       (clk_val),
        .rise          (rise),
        .fall          (fall),
        .err_overshoot (err_overshoot)
    );

    always #5 emu_clk = ~emu_clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint half(input longint t, input bit je, input int amp, input int l);
        longint b, m, v;
        b = (t == 0) ? 1 : t;
        m = je ? longint'(l & ((1 << JW) - 1) & amp) : 0;
        v = ((l >> 15) & 1) ? b - m : b + m;
        if (v < 1) v = 1;
        if (v > DT_MAX - 1) v = DT_MAX - 1;
        return v;
    endfunction

    function automatic int lfsr_next(input int l);
        int fb;
        fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
        return ((l << 1) | fb) & 16'hFFFF;
    endfunction

    longint m_rem;
    bit     m_on, m_lvl;
    int     m_lfsr;
    longint e_req;
    bit     e_rise, e_fall, e_err;

    always @(posedge emu_clk or negedge emu_rst_n) begin : model
        automatic longint r, d;
        automatic bit on, lv, ri, fa, er;
        automatic int l;
        if (!emu_rst_n) begin
            m_rem <= 0; m_on <= 0; m_lvl <= 0; m_lfsr <= 16'hACE1;
            e_req <= DT_MAX; e_rise <= 0; e_fall <= 0; e_err <= 0;
        end else begin
            r = m_rem; on = m_on; lv = m_lvl; l = m_lfsr; er = e_err;
            ri = 0; fa = 0; d = longint'(emu_dt);
            if (!on) begin
                if (en) begin
                    on = 1;
                    r  = half(longint'(t_lo), jit_en, int'(jit_amp), l);
                end
            end else begin
                if (d >= r) begin
                    if (d > r) er = 1;
                    lv = !lv;
                    if (lv) begin
                        ri = 1;
                        r  = half(longint'(t_hi), jit_en, int'(jit_amp), l);
                    end else begin
                        fa = 1;
                        r  = half(longint'(t_lo), jit_en, int'(jit_amp), l);
                    end
                    if (jit_en) l = lfsr_next(l);
                end else begin
                    r = r - d;
                end
                if (!en && !lv) on = 0;
            end
            m_rem <= r; m_on <= on; m_lvl <= lv; m_lfsr <= l;
            e_req <= on ? r : DT_MAX;
            e_rise <= ri; e_fall <= fa; e_err <= er;
        end
    end

    always @(negedge emu_clk) begin
        if (chk_on && emu_rst_n) begin
            chk("model_dt_req", longint'(dt_req), e_req);
            chk("model_clk_val", longint'(clk_val), longint'(m_lvl));
            chk("model_rise", longint'(rise), longint'(e_rise));
            chk("model_fall", longint'(fall), longint'(e_fall));
            chk("model_err", longint'(err_overshoot), longint'(e_err));
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic longint mn(input longint a, input longint b);
        return (a < b) ? a : b;
    endfunction

    task automatic step(input longint d);
        emu_dt = DT_W'(d);
        @(posedge emu_clk);
        #2;
    endtask

    task automatic do_reset();
        emu_rst_n = 1'b0;
        @(posedge emu_clk);
        #2;
        emu_rst_n = 1'b1;
    endtask

    task automatic wait_rise(input string name);
        bit got;
        got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            step(mn(4, longint'(dt_req)));
            got = rise;
        end
        if (!got) chk(name, 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        longint exp_req[6];
        bit     exp_rise[6], exp_fall[6];
        longint acc;
        int     sat;
        bit     got;
        exp_req  = '{10, 6, 2, 6, 2, 10};
        exp_rise = '{0, 0, 0, 1, 0, 0};
        exp_fall = '{0, 0, 0, 0, 0, 1};

        #1;
        do_reset();
        chk_on = 1'b1;
        chk("reset_dt_req", longint'(dt_req), DT_MAX);
        chk("reset_clk_val", longint'(clk_val), 0);
        chk("reset_rise_fall", longint'({rise, fall}), 0);
        chk("reset_err", longint'(err_overshoot), 0);

        // basic phase
        t_lo = 10; t_hi = 6; en = 1;
        for (int k = 0; k < 6; k++) begin
            step(mn(4, longint'(dt_req)));
            chk($sformatf("basic_req%0d", k), longint'(dt_req), exp_req[k]);
            chk($sformatf("basic_rise%0d", k), longint'(rise), longint'(exp_rise[k]));
            chk($sformatf("basic_fall%0d", k), longint'(fall), longint'(exp_fall[k]));
        end
        wait_rise("period_first_rise");
        acc = 0; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            acc += mn(4, longint'(dt_req));
            step(mn(4, longint'(dt_req)));
            got = rise;
        end
        chk("period_16", acc, 16);

        // emu_dt = 0 holds the remaining time
        for (int i = 0; i < 5; i++) begin
            step(0);
            chk("hold_rem", longint'(dt_req), 6);
        end

        // overshoot
        step(1);
        chk("ovs_rem5", longint'(dt_req), 5);
        step(7);
        chk("ovs_fall", longint'(fall), 1);
        chk("ovs_err", longint'(err_overshoot), 1);
        chk("ovs_reload", longint'(dt_req), 10);
        for (int i = 0; i < 3; i++) begin
            step(mn(4, longint'(dt_req)));
            chk("ovs_sticky", longint'(err_overshoot), 1);
        end

        // disable while high: drain to the falling edge
        t_hi = 11;
        wait_rise("drain_wait_rise");
        chk("drain_hi11", longint'(dt_req), 11);
        step(3);
        chk("drain_req8", longint'(dt_req), 8);
        en = 0;
        step(3);
        chk("drain_req5", longint'(dt_req), 5);
        chk("drain_still_hi", longint'(clk_val), 1);
        step(3);
        chk("drain_req2", longint'(dt_req), 2);
        step(2);
        chk("drain_fall", longint'(fall), 1);
        chk("drain_idle", longint'(dt_req), DT_MAX);
        step(0);
        chk("drain_idle_hold", longint'(dt_req), DT_MAX);

        // disable while low: IDLE after one cycle
        en = 1;
        step(4);
        chk("lowdis_start", longint'(dt_req), 10);
        step(4);
        chk("lowdis_req6", longint'(dt_req), 6);
        en = 0;
        step(4);
        chk("lowdis_idle", longint'(dt_req), DT_MAX);
        chk("lowdis_clk", longint'(clk_val), 0);

        // t_hi = 0 becomes 1; edge in the disabling cycle wins
        t_lo = 3; t_hi = 0; en = 1;
        wait_rise("thi0_wait_rise");
        chk("thi0_half1", longint'(dt_req), 1);
        step(1);
        chk("thi0_fall", longint'(fall), 1);
        chk("thi0_lo3", longint'(dt_req), 3);
        en = 0;
        step(3);
        chk("edgewins_rise", longint'(rise), 1);
        chk("edgewins_req", longint'(dt_req), 1);
        step(1);
        chk("edgewins_fall", longint'(fall), 1);
        chk("edgewins_idle", longint'(dt_req), DT_MAX);

        // saturation at DT_MAX-1
        do_reset();
        t_lo = DT_W'(DT_MAX - 1); t_hi = DT_W'(DT_MAX - 1);
        jit_en = 1; jit_amp = 8'hFF; en = 1;
        step(0);
        chk("sat_first", longint'(dt_req), DT_MAX - 1 - 225);
        sat = 0;
        for (int i = 0; i < 32; i++) begin
            step(longint'(dt_req));
            chk("sat_edge", longint'(rise | fall), 1);
            if (longint'(dt_req) == DT_MAX - 1) sat++;
        end
        chk("sat_hit", (sat > 0) ? 1 : 0, 1);

        // jitter
        do_reset();
        t_lo = 100; t_hi = 100; jit_amp = 3; jit_en = 1; en = 1;
        step(0);
        chk("jit_first", longint'(dt_req), 99);
        step(longint'(dt_req));
        chk("jit_rise1", longint'(rise), 1);
        chk("jit_second", longint'(dt_req), 99);
        step(longint'(dt_req));
        chk("jit_third", longint'(dt_req), 103);
        for (int i = 0; i < 998; i++) begin
            step(longint'(dt_req));
            chk("jit_range", (dt_req >= 97 && dt_req <= 103) ? 1 : 0, 1);
        end
        jit_amp = 0;
        for (int i = 0; i < 50; i++) begin
            step(longint'(dt_req));
            chk("jit_amp0", longint'(dt_req), 100);
        end

        // async reset while high
        if (!clk_val) step(longint'(dt_req));
        chk("arst_pre_high", longint'(clk_val), 1);
        #1 emu_rst_n = 1'b0;
        #1;
        chk("arst_dt_req", longint'(dt_req), DT_MAX);
        chk("arst_clk", longint'(clk_val), 0);
        chk("arst_pulses", longint'({rise, fall}), 0);
        chk("arst_err", longint'(err_overshoot), 0);
        @(posedge emu_clk);
        #2;
        jit_en = 0; t_lo = 10; t_hi = 6;
        emu_rst_n = 1'b1;
        step(4);
        chk("arst_restart", longint'(dt_req), 10);
        step(4);
        chk("arst_run", longint'(dt_req), 6);

        en = 0;
        step(0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/osc_model.md
# osc_model

Emulated-time oscillator for the FPGA emulator. It sits directly upstream of the time manager. Each `emu_clk` cycle it publishes `dt_req`, the emulated time remaining until its next clock edge. It consumes the granted `emu_dt` and toggles its emulated clock `clk_val` exactly when the remaining time reaches zero. The RX and TX clock generators in the testbench each instantiate one of these to drive the time manager's `rx_dt` and `tx_dt` inputs.

## Interface
Parameters:
- `DT_WIDTH`, 27: width of all emulated-time quantities; unsigned, LSB = one time unit.
- `JIT_WIDTH`, 8: width of the jitter amplitude.
- `SEED`, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- `emu_clk`, in, 1: emulator clock. One clock domain only.
- `emu_rst_n`, in, 1: reset, asynchronous, active-low.
- `emu_dt`, in, DT_WIDTH: time step granted this cycle. Normally ≤ `dt_req`.
- `en`, in, 1: oscillator enable.
- `t_hi`, in, DT_WIDTH: high half-period.
- `t_lo`, in, DT_WIDTH: low half-period.
- `jit_en`, in, 1: enables jitter.
- `jit_amp`, in, JIT_WIDTH: bitmask applied to the jitter magnitude.
- `dt_req`, out, DT_WIDTH: time remaining to the next edge. All ones (`DT_MAX`) means no constraint.
- `clk_val`, out, 1: emulated clock level.
- `rise`, out, 1: one-cycle pulse in the cycle `clk_val` becomes 1.
- `fall`, out, 1: one-cycle pulse in the cycle `clk_val` becomes 0.
- `err_overshoot`, out, 1: sticky; set when `emu_dt > dt_req` in RUN or DRAIN.

## Operation
- FSM states: IDLE, RUN, DRAIN. Internal register `rem` (DT_WIDTH bits).
- IDLE:
  - `clk_val`=0, `dt_req`=`DT_MAX`, `emu_dt` ignored.
  - If `en`=1: next state RUN, `rem` ← `t_lo` (time to first rising edge).
- RUN / DRAIN, each cycle:
  - If `emu_dt` ≥ `rem`: edge occurs.
    - Toggle `clk_val` and pulse `rise` or `fall`.
    - Reload `rem` with the next half-period: `t_hi` after a rise, `t_lo` after a fall, jitter applied.
    - If `emu_dt` > `rem`, also set `err_overshoot`.
  - Otherwise: `rem` ← `rem` − `emu_dt`. An `emu_dt` of 0 holds `rem`.
- RUN, `en`=0:
  - If `clk_val`=0: go to IDLE next cycle; `rem` is discarded. If an edge occurs in this same cycle, the edge wins: enter DRAIN.
  - If `clk_val`=1: go to DRAIN.
- DRAIN:
  - Keeps running until the falling edge, then goes to IDLE. No glitch or truncated high phase.
  - Re-asserting `en` in DRAIN returns to RUN without disturbing `rem`.
- Half-period computation, done in DT_WIDTH+1 bits:
  - Base: a half-period of 0 is treated as 1.
  - Jitter: if `jit_en`, offset m = `lfsr[JIT_WIDTH-1:0]` & `jit_amp`. Add m if `lfsr[15]`=0, subtract m if `lfsr[15]`=1.
  - Saturation: result clamps to the range [1, `DT_MAX`−1]. `DT_MAX` is reserved.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances once per edge, only when `jit_en`=1.
- `dt_req` = `rem` in RUN and DRAIN; `DT_MAX` in IDLE.

## Timing
- `dt_req`, `clk_val`, `rise`, `fall` and `err_overshoot` are all registered. There is no combinational path from `emu_dt` to `dt_req`, because the time manager feeds `emu_dt` back combinationally.
- Edge latency: `clk_val` changes on the `emu_clk` edge that consumes the final `emu_dt`. The new `dt_req` is valid in the same following cycle.
- First edge: the IDLE→RUN transition takes 1 cycle; the first rising edge comes `t_lo` time units later.
- `t_hi`, `t_lo`, `jit_amp` and `jit_en` are sampled only at reload, or at IDLE→RUN. Changing them mid-phase has no effect on the current phase.
- Reset values, applied asynchronously with no clock required:
  - state IDLE, `rem`=0, `dt_req`=`DT_MAX`;
  - `clk_val`=0, `rise`=`fall`=0;
  - `err_overshoot`=0, `lfsr`=`SEED`.
- Reset release is synchronous to `emu_clk` in the integrating design.

## Structure
- Package `osc_pkg` holds:
  - the state enum `osc_state_t`;
  - the `DT_MAX` function of DT_WIDTH;
  - the LFSR tap constant and `SEED` default.
  The time manager shares `DT_MAX` from this package.
- Sub-module `osc_lfsr`: 16-bit LFSR with an `adv` input and async active-low reset. Everything else stays in `osc_model`.

## Test plan
- **Basic phase, no jitter:** `t_lo`=10, `t_hi`=6, `en`=1. Bench drives `emu_dt`=min(4,`dt_req`). Required `dt_req` sequence: `DT_MAX`, 10, 6, 2, then `rise`=1 and `dt_req`=6. Then 2, then `fall`=1 and `dt_req`=10. Period is exactly 16.
- **Overshoot:** with `rem`=5, drive `emu_dt`=7. Required: edge taken, `err_overshoot`=1, and it stays 1 through later cycles until `emu_rst_n`=0.
- **Disable while high:** drop `en` while `clk_val`=1 and `rem`=8, with `emu_dt`=3. Required: DRAIN sequence 8, 5, 2, then `fall`, then `dt_req`=`DT_MAX`. Disable while low goes to IDLE in 1 cycle.
- **Jitter:** `t_hi`=`t_lo`=100, `jit_amp`=3, 1000 edges. Required: every half-period is in [97,103] and matches a reference LFSR model bit-exactly. With `jit_amp`=0, all half-periods are exactly 100.
- **Boundaries:**
  - `t_hi`=0 gives a half-period of 1.
  - `t_lo`=`DT_MAX`−1 with `jit_amp`=255 saturates at `DT_MAX`−1.
  - `emu_dt`=0 for 5 cycles holds `rem`.
- **Async reset mid-run:** assert `emu_rst_n`=0 between clock edges while `clk_val`=1. Required: all outputs reach their reset values before the next `emu_clk` edge. After release with `en`=1, operation restarts with `dt_req`=`t_lo`.
